// File: rtl/cbs_pkg.sv
// Shared widths and the writer FSM state type for the convolution-result path.
package cbs_pkg;
    localparam int CBS_DATA_W     = 19;
    localparam int CBS_IDX_W      = 15;
    localparam int CBS_OUT_W      = 16;
    localparam int CBS_ADDR_W     = 16;
    localparam int CBS_MAP_W      = 224;
    localparam int CBS_MAP_H      = 224;
    localparam int RES_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } wr_state_e;
endpackage

// File: rtl/fmap_result_writer_if.sv
// Result-in / memory-write bundle of fmap_result_writer; master drives results and
// memory ready, slave (the writer) drives the memory write and status side.
interface fmap_result_writer_if import cbs_pkg::*; #(
    parameter int DATA_W = CBS_DATA_W,
    parameter int IDX_W  = CBS_IDX_W,
    parameter int OUT_W  = CBS_OUT_W,
    parameter int ADDR_W = CBS_ADDR_W
);
    logic                     res_valid;
    logic signed [DATA_W-1:0] res_data;
    logic [IDX_W-1:0]         res_row;
    logic [IDX_W-1:0]         res_col;
    logic                     mem_ready;
    logic                     mem_we;
    logic [ADDR_W-1:0]        mem_addr;
    logic [OUT_W-1:0]         mem_wdata;
    logic                     frame_done;
    logic                     ovf_err;
    logic                     seq_err;
    logic [ADDR_W:0]          wr_count;

    modport master (
        output res_valid, res_data, res_row, res_col, mem_ready,
        input  mem_we, mem_addr, mem_wdata, frame_done, ovf_err, seq_err, wr_count
    );
    modport slave (
        input  res_valid, res_data, res_row, res_col, mem_ready,
        output mem_we, mem_addr, mem_wdata, frame_done, ovf_err, seq_err, wr_count
    );
endinterface

// File: rtl/result_fifo.sv
// Small register FIFO for {addr, word} entries; push is accepted when full only if a pop
// happens in the same cycle.
module result_fifo import cbs_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int DEPTH = RES_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             empty_next_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o       = (cnt_q == CNT_W'(DEPTH));
    assign empty_o      = (cnt_q == '0);
    assign pop_ok       = pop_i && !empty_o;
    assign push_ok      = push_i && (!full_o || pop_ok);
    assign cnt_d        = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    assign empty_next_o = (cnt_d == '0);
    assign rdata_o      = mem_q[rd_ptr_q];

    // Storage is cleared too so the memory-side outputs read zero out of reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/fmap_result_writer.sv
// Writes each convolution result into the feature-map memory at row*MAP_W+col, checks raster order.
// Build option: define RESULT_CLAMP_EN to saturate results to signed OUT_W instead of truncating.
module fmap_result_writer import cbs_pkg::*; #(
    parameter int DATA_W = CBS_DATA_W,
    parameter int IDX_W  = CBS_IDX_W,
    parameter int MAP_W  = CBS_MAP_W,
    parameter int MAP_H  = CBS_MAP_H,
    parameter int OUT_W  = CBS_OUT_W,
    parameter int ADDR_W = CBS_ADDR_W
) (
    input logic                 clk,
    input logic                 reset,
    fmap_result_writer_if.slave wr_if
);
`ifdef RESULT_CLAMP_EN
    localparam bit CLAMP = 1'b1;
`else
    localparam bit CLAMP = 1'b0;
`endif
    localparam logic signed [DATA_W-1:0] SAT_MAX  = DATA_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [DATA_W-1:0] SAT_MIN  = ~SAT_MAX;
    localparam logic [IDX_W-1:0]         LAST_COL = IDX_W'(MAP_W - 1);
    localparam logic [IDX_W-1:0]         LAST_ROW = IDX_W'(MAP_H - 1);
    localparam int                       ENT_W    = ADDR_W + OUT_W;

    wr_state_e         state_q;
    logic [IDX_W-1:0]  exp_row_q, exp_col_q, nxt_row, nxt_col;
    logic              ovf_q, seq_q;
    logic [ADDR_W:0]   wr_count_q;
    logic              in_range, push, pop, is_last, seq_miss, sat_hi, sat_lo;
    logic [ADDR_W-1:0] push_addr;
    logic [OUT_W-1:0]  push_word;
    logic [ENT_W-1:0]  head;
    logic              fifo_full, fifo_empty, fifo_empty_next;

    assign in_range  = (32'(wr_if.res_row) < MAP_H) && (32'(wr_if.res_col) < MAP_W);
    assign push      = wr_if.res_valid && in_range;
    assign pop       = !fifo_empty && wr_if.mem_ready;
    assign push_addr = ADDR_W'(32'(wr_if.res_row) * 32'(MAP_W) + 32'(wr_if.res_col));
    assign is_last   = (wr_if.res_row == LAST_ROW) && (wr_if.res_col == LAST_COL);
    assign seq_miss  = (wr_if.res_row != exp_row_q) || (wr_if.res_col != exp_col_q);

    assign sat_hi    = CLAMP && (wr_if.res_data > SAT_MAX);
    assign sat_lo    = CLAMP && (wr_if.res_data < SAT_MIN);
    assign push_word = sat_hi ? SAT_MAX[OUT_W-1:0] :
                       sat_lo ? SAT_MIN[OUT_W-1:0] : wr_if.res_data[OUT_W-1:0];

    // Raster successor of the incoming index; the last pixel wraps to (0,0) for the next frame.
    always_comb begin
        nxt_row = wr_if.res_row;
        nxt_col = wr_if.res_col + IDX_W'(1);
        if (wr_if.res_col == LAST_COL) begin
            nxt_col = '0;
            nxt_row = (wr_if.res_row == LAST_ROW) ? '0 : wr_if.res_row + IDX_W'(1);
        end
    end

    result_fifo #(.WIDTH(ENT_W), .DEPTH(RES_FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .pop_i        (pop),
        .wdata_i      ({push_addr, push_word}),
        .rdata_o      (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .empty_next_o (fifo_empty_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            exp_row_q  <= '0;
            exp_col_q  <= '0;
            ovf_q      <= 1'b0;
            seq_q      <= 1'b0;
            wr_count_q <= '0;
        end else begin
            if (wr_if.res_valid) begin
                if (!in_range) begin
                    seq_q <= 1'b1;
                end else begin
                    if (seq_miss) seq_q <= 1'b1;
                    exp_row_q <= nxt_row;
                    exp_col_q <= nxt_col;
                    if (fifo_full && !pop) ovf_q <= 1'b1;
                end
            end
            if (state_q == DONE)  wr_count_q <= '0;
            else if (pop)         wr_count_q <= wr_count_q + 1'b1;
            case (state_q)
                IDLE:    if (push) state_q <= is_last ? DRAIN : COLLECT;
                COLLECT: if (push && is_last) state_q <= DRAIN;
                DRAIN:   if (fifo_empty_next) state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_if.mem_we     = !fifo_empty;
    assign wr_if.mem_addr   = head[ENT_W-1:OUT_W];
    assign wr_if.mem_wdata  = head[OUT_W-1:0];
    assign wr_if.frame_done = (state_q == DONE);
    assign wr_if.ovf_err    = ovf_q;
    assign wr_if.seq_err    = seq_q;
    assign wr_if.wr_count   = wr_count_q;
endmodule

// File: tb/tb_fmap_result_writer.sv
// Directed bench for fmap_result_writer on a 4x4 map; memory writes are logged by a monitor.
module tb_fmap_result_writer;
    import cbs_pkg::*;
    localparam int MW = 4;
    localparam int MH = 4;

`ifdef RESULT_CLAMP_EN
    localparam logic [15:0] EXP_M1 = 16'hFFFF, EXP_BIG = 16'h7FFF, EXP_NEG = 16'h8000;
`else
    localparam logic [15:0] EXP_M1 = 16'hFFFF, EXP_BIG = 16'hFFFF, EXP_NEG = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fmap_result_writer_if wr_if ();

    fmap_result_writer #(.MAP_W(MW), .MAP_H(MH)) dut (
        .clk   (clk),
        .reset (rst_n),
        .wr_if (wr_if)
    );

    int errs = 0;
    int nchk = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int done_wrc = 0;
    logic [15:0] wq_addr[$];
    logic [15:0] wq_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && wr_if.mem_we && wr_if.mem_ready) begin
            wq_addr.push_back(wr_if.mem_addr);
            wq_data.push_back(wr_if.mem_wdata);
            last_wr_cyc = cyc;
        end
        if (rst_n && wr_if.frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_wrc = int'(wr_if.wr_count);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int r, input int c, input logic [18:0] d);
        wr_if.res_valid = 1'b1;
        wr_if.res_row   = r[14:0];
        wr_if.res_col   = c[14:0];
        wr_if.res_data  = d;
        tick();
        wr_if.res_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_if.res_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
    endtask

    task automatic check_write(input string tag, input int idx, input logic [15:0] a, input logic [15:0] d);
        if (idx < wq_addr.size()) begin
            check({tag, "_addr"}, 32'(wq_addr[idx]), 32'(a));
            check({tag, "_data"}, 32'(wq_data[idx]), 32'(d));
        end else begin
            check({tag, "_present"}, 32'(wq_addr.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        wr_if.res_valid = 1'b0;
        wr_if.res_row   = '0;
        wr_if.res_col   = '0;
        wr_if.res_data  = '0;
        wr_if.mem_ready = 1'b1;

        // reset state, with a strobe held during reset that must be ignored
        rst_n = 1'b0;
        wr_if.res_valid = 1'b1;
        wr_if.res_data  = 19'h00123;
        tick();
        tick();
        check("rst_we",    32'(wr_if.mem_we), 32'd0);
        check("rst_addr",  32'(wr_if.mem_addr), 32'd0);
        check("rst_wdata", 32'(wr_if.mem_wdata), 32'd0);
        check("rst_done",  32'(wr_if.frame_done), 32'd0);
        check("rst_ovf",   32'(wr_if.ovf_err), 32'd0);
        check("rst_seq",   32'(wr_if.seq_err), 32'd0);
        check("rst_wrc",   32'(wr_if.wr_count), 32'd0);
        wr_if.res_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        check("rel_we", 32'(wr_if.mem_we), 32'd0);

        // full in-order frame
        do_reset();
        for (int k = 0; k < 16; k++) begin
            strobe(k / MW, k % MW, 19'(k * 257));
            if (k == 0) begin
                check("lat_we",   32'(wr_if.mem_we), 32'd1);
                check("lat_addr", 32'(wr_if.mem_addr), 32'd0);
            end
        end
        for (int i = 0; i < 10; i++) tick();
        check("frm_nwr", 32'(wq_addr.size()), 32'd16);
        for (int k = 0; k < 16; k++) check_write($sformatf("frm%0d", k), k, 16'(k), 16'(k * 257));
        check("frm_done_cnt", 32'(done_cnt), 32'd1);
        check("frm_done_lat", 32'(done_cyc - last_wr_cyc), 32'd1);
        check("frm_wrc",      32'(done_wrc), 32'd16);
        check("frm_wrc_clr",  32'(wr_if.wr_count), 32'd0);
        check("frm_seq",      32'(wr_if.seq_err), 32'd0);
        check("frm_ovf",      32'(wr_if.ovf_err), 32'd0);

        // overflow while memory stalls
        do_reset();
        wr_if.mem_ready = 1'b0;
        for (int k = 0; k < 6; k++) strobe(k / MW, k % MW, 19'(k + 100));
        check("ovf_flag",  32'(wr_if.ovf_err), 32'd1);
        check("ovf_held",  32'(wr_if.mem_we), 32'd1);
        check("ovf_nowr",  32'(wq_addr.size()), 32'd0);
        wr_if.mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("ovf_nwr", 32'(wq_addr.size()), 32'd4);
        for (int k = 0; k < 4; k++) check_write($sformatf("ovf%0d", k), k, 16'(k), 16'(k + 100));
        check("ovf_sticky", 32'(wr_if.ovf_err), 32'd1);
        check("ovf_wrc",    32'(wr_if.wr_count), 32'd4);
        check("ovf_seq",    32'(wr_if.seq_err), 32'd0);

        // out-of-range column is dropped and flagged
        do_reset();
        strobe(0, 5, 19'h00042);
        for (int i = 0; i < 3; i++) tick();
        check("rng_seq",  32'(wr_if.seq_err), 32'd1);
        check("rng_drop", 32'(wq_addr.size()), 32'd0);

        // out-of-order index still written at its own address
        do_reset();
        check("seq_rst", 32'(wr_if.seq_err), 32'd0);
        strobe(0, 0, 19'h00011);
        check("seq_ok", 32'(wr_if.seq_err), 32'd0);
        strobe(1, 2, 19'h00022);
        tick();
        tick();
        check("seq_flag", 32'(wr_if.seq_err), 32'd1);
        check("seq_nwr",  32'(wq_addr.size()), 32'd2);
        check_write("seq0", 0, 16'd0, 16'h0011);
        check_write("seq1", 1, 16'd6, 16'h0022);

        // word formation at the OUT_W boundary
        do_reset();
        strobe(0, 0, 19'h7FFFF);
        strobe(0, 1, 19'h1FFFF);
        strobe(0, 2, 19'h40000);
        for (int i = 0; i < 3; i++) tick();
        check_write("wf_m1",  0, 16'd0, EXP_M1);
        check_write("wf_big", 1, 16'd1, EXP_BIG);
        check_write("wf_neg", 2, 16'd2, EXP_NEG);

        // reset with entries queued and a sticky flag set
        do_reset();
        wr_if.mem_ready = 1'b0;
        strobe(0, 0, 19'h00001);
        strobe(0, 1, 19'h00002);
        strobe(2, 2, 19'h00003);
        check("mr_we_pre",  32'(wr_if.mem_we), 32'd1);
        check("mr_seq_pre", 32'(wr_if.seq_err), 32'd1);
        rst_n = 1'b0;
        tick();
        check("mr_we",    32'(wr_if.mem_we), 32'd0);
        check("mr_addr",  32'(wr_if.mem_addr), 32'd0);
        check("mr_wdata", 32'(wr_if.mem_wdata), 32'd0);
        check("mr_seq",   32'(wr_if.seq_err), 32'd0);
        check("mr_ovf",   32'(wr_if.ovf_err), 32'd0);
        check("mr_wrc",   32'(wr_if.wr_count), 32'd0);
        check("mr_done",  32'(wr_if.frame_done), 32'd0);
        rst_n = 1'b1;
        wr_if.mem_ready = 1'b1;
        tick();
        check("mr_rel_we", 32'(wr_if.mem_we), 32'd0);
        tick();
        check("mr_nwr", 32'(wq_addr.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
